// File: rtl/packet_receiver.sv
// Byte-serial packet receiver: writes each byte into the current
// input-buffer slot, checks the XOR checksum and commits clean packets.
module packet_receiver #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 packet_valid,
  input  logic [UWIDTH-1:0]    packet_in,
  input  logic                 wfull,
  output logic                 wen,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 winc,
  output logic                 crc_err,
  output logic                 frm_err,
  output logic                 drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_DST, S_SIZE, S_DATA,
    S_CRC, S_DONE, S_DISCARD
  } state_t;

  state_t state, state_n;

  logic [UWIDTH-1:0]    chk;
  logic [SIZE_BITS-1:0] cnt;
  logic [PTR_IN_SZ-1:0] ofs;
  logic                 match;

  logic [SIZE_BITS-1:0] n_field;
  logic                 wen_d;
  logic [PTR_IN_SZ-1:0] waddr_d;
  logic                 winc_d;
  logic                 crc_d;
  logic                 frm_d;
  logic                 drop_d;

  assign n_field = packet_in[SIZE_BITS-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (packet_valid)
          state_n = wfull ? S_DISCARD : S_DST;
      S_DST:
        state_n = packet_valid ? S_SIZE : S_IDLE;
      S_SIZE:
        if (!packet_valid)
          state_n = S_IDLE;
        else if (n_field == '0)
          state_n = S_DISCARD;
        else
          state_n = S_DATA;
      S_DATA:
        if (!packet_valid)
          state_n = S_IDLE;
        else if (cnt == SIZE_BITS'(1))
          state_n = S_CRC;
      S_CRC:
        state_n = packet_valid ? S_DONE : S_IDLE;
      S_DONE:
        state_n = packet_valid ? S_DISCARD : S_IDLE;
      S_DISCARD:
        if (!packet_valid) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // Output decode: values registered onto the ports next cycle
  always_comb begin
    wen_d   = 1'b0;
    winc_d  = 1'b0;
    crc_d   = 1'b0;
    frm_d   = 1'b0;
    drop_d  = 1'b0;
    waddr_d = (state == S_IDLE) ? '0 : ofs;
    unique case (state)
      S_IDLE: begin
        wen_d  = packet_valid & ~wfull;
        drop_d = packet_valid & wfull;
      end
      S_DST, S_DATA, S_CRC: begin
        wen_d = packet_valid;
        frm_d = ~packet_valid;
      end
      S_SIZE: begin
        wen_d = packet_valid;
        frm_d = ~packet_valid | (n_field == '0);
      end
      S_DONE: begin
        winc_d  = match;
        crc_d   = ~match;
        frm_d   = packet_valid;
      end
      default: ;
    endcase
  end

  // Registered write port and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen      <= 1'b0;
      waddr_in <= '0;
      wdata    <= '0;
      winc     <= 1'b0;
      crc_err  <= 1'b0;
      frm_err  <= 1'b0;
      drop     <= 1'b0;
    end else begin
      wen     <= wen_d;
      winc    <= winc_d;
      crc_err <= crc_d;
      frm_err <= frm_d;
      drop    <= drop_d;
      if (wen_d) begin
        waddr_in <= waddr_d;
        wdata    <= packet_in;
      end
    end
  end

  // Checksum, slot offset, data count and CRC verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk   <= '0;
      cnt   <= '0;
      ofs   <= '0;
      match <= 1'b0;
    end else begin
      if (wen_d) begin
        chk <= (state == S_IDLE) ? packet_in : (chk ^ packet_in);
        ofs <= waddr_d + 1'b1;
      end
      if (packet_valid && state == S_SIZE)
        cnt <= n_field;
      if (packet_valid && state == S_DATA)
        cnt <= cnt - 1'b1;
      if (packet_valid && state == S_CRC)
        match <= (chk == packet_in);
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: good, bad-CRC, framing,
// full-buffer, back-to-back and async-reset scenarios.
module tb_packet_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       packet_valid;
  logic [7:0] packet_in;
  logic       wfull;
  logic       wen;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic       winc;
  logic       crc_err;
  logic       frm_err;
  logic       drop;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] pkt[$];

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_WINC = 4'b1000;
  localparam logic [3:0] F_CRC  = 4'b0100;
  localparam logic [3:0] F_FRM  = 4'b0010;
  localparam logic [3:0] F_DROP = 4'b0001;

  packet_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .packet_valid (packet_valid),
    .packet_in    (packet_in),
    .wfull        (wfull),
    .wen          (wen),
    .waddr_in     (waddr_in),
    .wdata        (wdata),
    .winc         (winc),
    .crc_err      (crc_err),
    .frm_err      (frm_err),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic       e_wen,
    input logic [3:0] e_addr,
    input logic [7:0] e_data,
    input logic [3:0] e_flg
  );
    n_chk++;
    assert ({wen, winc, crc_err, frm_err, drop} === {e_wen, e_flg})
    else begin
      n_fail++;
      $error("FAIL %s ctl got %b exp %b", tag,
             {wen, winc, crc_err, frm_err, drop}, {e_wen, e_flg});
    end
    if (e_wen) begin
      n_chk++;
      assert ({waddr_in, wdata} === {e_addr, e_data})
      else begin
        n_fail++;
        $error("FAIL %s wr got %h/%h exp %h/%h", tag,
               waddr_in, wdata, e_addr, e_data);
      end
    end
  endtask

  // Drive one cycle, then sample just after the edge.
  task automatic step(
    input string      tag,
    input logic       v,
    input logic [7:0] b,
    input logic       wf,
    input logic       e_wen,
    input logic [3:0] e_addr,
    input logic [3:0] e_flg
  );
    @(negedge clk);
    packet_valid = v;
    packet_in    = b;
    wfull        = wf;
    @(posedge clk);
    #1;
    check(tag, e_wen, e_addr, b, e_flg);
  endtask

  task automatic send_writes(input string tag);
    for (int i = 0; i < pkt.size(); i++)
      step(tag, 1'b1, pkt[i], 1'b0, 1'b1, 4'(i), F_NONE);
  endtask

  task automatic send_pkt(input string tag, input logic [3:0] flg);
    send_writes(tag);
    step({tag, "_end"}, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, flg);
    step({tag, "_gap"}, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
  endtask

  initial begin
    rst = 1'b1;
    packet_valid = 1'b0;
    packet_in = 8'h00;
    wfull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 4'h0, 8'h00, F_NONE);
    n_chk++;
    assert ({waddr_in, wdata} === 12'h000)
    else begin
      n_fail++;
      $error("FAIL reset_addr got %h/%h exp 0/00", waddr_in, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);

    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_pkt("good", F_WINC);

    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA4};
    send_pkt("badcrc", F_CRC);

    step("z_src", 1'b1, 8'h01, 1'b0, 1'b1, 4'h0, F_NONE);
    step("z_dst", 1'b1, 8'h02, 1'b0, 1'b1, 4'h1, F_NONE);
    step("z_size", 1'b1, 8'h00, 1'b0, 1'b1, 4'h2, F_FRM);
    step("z_disc1", 1'b1, 8'h55, 1'b0, 1'b0, 4'h0, F_NONE);
    step("z_disc2", 1'b1, 8'h66, 1'b0, 1'b0, 4'h0, F_NONE);
    step("z_gap", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    step("z_idle", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);

    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0};
    send_writes("mid");
    step("mid_drop", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_FRM);
    step("mid_gap", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_pkt("mid_next", F_WINC);

    step("full_src", 1'b1, 8'h01, 1'b1, 1'b0, 4'h0, F_DROP);
    for (int i = 1; i < 7; i++)
      step("full_body", 1'b1, pkt[i], 1'b0, 1'b0, 4'h0, F_NONE);
    step("full_gap", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    step("full_idle", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    send_pkt("full_next", F_WINC);

    pkt = '{8'h01, 8'h02, 8'h07, 8'h10, 8'h20, 8'h30,
            8'h40, 8'h50, 8'h60, 8'h70, 8'h04};
    send_pkt("max", F_WINC);

    pkt = '{8'h01, 8'h02, 8'hF9, 8'hAA, 8'h50};
    send_pkt("hibits", F_WINC);

    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_writes("b2b");
    step("b2b_next", 1'b1, 8'h05, 1'b0, 1'b0, 4'h0, F_WINC | F_FRM);
    step("b2b_disc", 1'b1, 8'h06, 1'b0, 1'b0, 4'h0, F_NONE);
    step("b2b_gap", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    step("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);

    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0};
    send_writes("rstmid");
    @(negedge clk);
    packet_valid = 1'b1;
    packet_in = 8'hA1;
    rst = 1'b1;
    #1;
    check("rst_async", 1'b0, 4'h0, 8'h00, F_NONE);
    n_chk++;
    assert ({waddr_in, wdata} === 12'h000)
    else begin
      n_fail++;
      $error("FAIL rst_async_addr got %h/%h exp 0/00",
             waddr_in, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    packet_valid = 1'b0;
    step("rst_gap1", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    step("rst_gap2", 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, F_NONE);
    pkt = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_pkt("rst_next", F_WINC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
